// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gating controller.
// Optional build macro: CLK_GATE_CTRL_STATS_EN (adds gated-cycle statistics).
package clk_gate_ctrl_pkg;

    // Per-channel sequencer states
    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_COUNT = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    // Width of the optional per-channel gated-cycle counters
    localparam int STATS_W = 32;

    // Width needed to hold values 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Bundle of the per-channel control/status vectors of clk_gate_ctrl.
// Optional build macro: CLK_GATE_CTRL_STATS_EN adds stats_clr/gated_cnt.
//
// Handshake: wake_req[i] is a level held by the requester until it sees
// wake_ack[i]; wake_ack[i] is a one-cycle pulse, issued at most once per
// request. busy/gate_dis are plain levels sampled every clk rising edge.
interface clk_gate_ctrl_if #(
    parameter int N_CH = 4
);
    import clk_gate_ctrl_pkg::*;

    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] wake_req;
    logic [N_CH-1:0] gate_dis;
    logic [N_CH-1:0] cg_en;
    logic [N_CH-1:0] wake_ack;
    logic [N_CH-1:0] gated;
    // Debug view of each channel's sequencer state
    cg_state_e       state [N_CH];

`ifdef CLK_GATE_CTRL_STATS_EN
    logic               stats_clr;
    logic [STATS_W-1:0] gated_cnt [N_CH];

    modport master (
        output busy, wake_req, gate_dis, stats_clr,
        input  cg_en, wake_ack, gated, state, gated_cnt
    );

    modport slave (
        input  busy, wake_req, gate_dis, stats_clr,
        output cg_en, wake_ack, gated, state, gated_cnt
    );
`else
    modport master (
        output busy, wake_req, gate_dis,
        input  cg_en, wake_ack, gated, state
    );

    modport slave (
        input  busy, wake_req, gate_dis,
        output cg_en, wake_ack, gated, state
    );
`endif

endinterface

// File: rtl/clk_gate_ctrl_chan.sv
// One channel of the clock-gating controller: idle detector, gating FSM,
// wake-latency counter and (optionally) a saturating gated-cycle counter.
// Optional build macro: CLK_GATE_CTRL_STATS_EN.
module clk_gate_chan
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = $clog2(IDLE_CYC + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               busy,
    input  logic               wake_req,
    input  logic               gate_dis,
`ifdef CLK_GATE_CTRL_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] gated_cnt,
`endif
    output logic               cg_en,
    output logic               wake_ack,
    output logic               gated,
    output cg_state_e          state
);

    localparam int WAIT_W = cnt_width(WAKE_LAT);

    logic              idle;
    logic [CNT_W-1:0]  idle_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    // Set once the current wake_req has been acknowledged; cleared when it drops
    logic              acked;
    logic              new_req;

    assign idle    = !busy && !wake_req && !gate_dis;
    assign new_req = wake_req && !acked;

    // Gating sequencer; all outputs are registered so cg_en only moves on
    // the rising edge, while the ICG latch is closed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CG_RUN;
            idle_cnt <= '0;
            wait_cnt <= '0;
            cg_en    <= 1'b1;
            wake_ack <= 1'b0;
            gated    <= 1'b0;
            acked    <= 1'b0;
        end else begin
            wake_ack <= 1'b0;
            if (!wake_req) begin
                acked <= 1'b0;
            end

            case (state)
                CG_RUN: begin
                    // Clock is already running, so a request is acked at once
                    if (new_req) begin
                        wake_ack <= 1'b1;
                        acked    <= 1'b1;
                    end
                    if (idle) begin
                        state    <= CG_COUNT;
                        idle_cnt <= CNT_W'(1);
                    end else begin
                        idle_cnt <= '0;
                    end
                end

                CG_COUNT: begin
                    if (!idle) begin
                        state    <= CG_RUN;
                        idle_cnt <= '0;
                        if (new_req) begin
                            wake_ack <= 1'b1;
                            acked    <= 1'b1;
                        end
                    end else if (idle_cnt == CNT_W'(IDLE_CYC)) begin
                        state <= CG_GATED;
                        cg_en <= 1'b0;
                        gated <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end

                CG_GATED: begin
                    if (busy || wake_req || gate_dis) begin
                        state    <= CG_WAKE;
                        cg_en    <= 1'b1;
                        gated    <= 1'b0;
                        wait_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end

                CG_WAKE: begin
                    // Ack only if the requester is still waiting at expiry
                    if (wait_cnt == WAIT_W'(WAKE_LAT - 1)) begin
                        state <= CG_RUN;
                        if (wake_req) begin
                            wake_ack <= 1'b1;
                            acked    <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                default: begin
                    state    <= CG_RUN;
                    idle_cnt <= '0;
                    cg_en    <= 1'b1;
                    gated    <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_GATE_CTRL_STATS_EN
    // Saturating count of cycles spent with gated=1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gated_cnt <= '0;
        end else if (stats_clr) begin
            gated_cnt <= '0;
        end else if (gated && (gated_cnt != {STATS_W{1'b1}})) begin
            gated_cnt <= gated_cnt + STATS_W'(1);
        end
    end
`endif

endmodule

// File: rtl/clk_gate_ctrl.sv
// Top of the clock-gating controller: N_CH independent channels, each
// driving the enable of one downstream ICG cell.
// Optional build macro: CLK_GATE_CTRL_STATS_EN (gated-cycle counters).
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = $clog2(IDLE_CYC + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_gate_ctrl_if.slave  bus
);

    logic [N_CH-1:0] cg_en_v;
    logic [N_CH-1:0] wake_ack_v;
    logic [N_CH-1:0] gated_v;
    cg_state_e       state_v [N_CH];
`ifdef CLK_GATE_CTRL_STATS_EN
    logic [STATS_W-1:0] gated_cnt_v [N_CH];
`endif

    // One sequencer per channel; no interaction between channels
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_gate_chan #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_LAT (WAKE_LAT),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .busy      (bus.busy[i]),
            .wake_req  (bus.wake_req[i]),
            .gate_dis  (bus.gate_dis[i]),
`ifdef CLK_GATE_CTRL_STATS_EN
            .stats_clr (bus.stats_clr),
            .gated_cnt (gated_cnt_v[i]),
`endif
            .cg_en     (cg_en_v[i]),
            .wake_ack  (wake_ack_v[i]),
            .gated     (gated_v[i]),
            .state     (state_v[i])
        );
    end

    assign bus.cg_en    = cg_en_v;
    assign bus.wake_ack = wake_ack_v;
    assign bus.gated    = gated_v;
    assign bus.state    = state_v;
`ifdef CLK_GATE_CTRL_STATS_EN
    assign bus.gated_cnt = gated_cnt_v;
`endif

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Per-channel idle-detect and wake sequencer that drives the enable inputs of N downstream ICG cells.
- Each channel's enable is held high while its logic is busy.
- After IDLE_CYC consecutive idle cycles the enable drops, gating that channel's clock.
- A wake request restores the enable, and an ack is returned WAKE_LAT cycles later so the requester knows the gated clock is running again.

Parameters:
- N_CH, 4, number of gated channels (1..16).
- IDLE_CYC, 16, consecutive idle cycles before gating (>=1).
- WAKE_LAT, 2, cycles from enable re-assertion to wake_ack (>=1).
- CNT_W, $clog2(IDLE_CYC+1), idle counter width.

Ports:
- clk  input  1  free-running clock, also the source clock of the ICGs.
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
- busy  input  N_CH  channel i logic active; forces/keeps channel awake.
- wake_req  input  N_CH  request to ungate channel i; level, held until wake_ack.
- gate_dis  input  N_CH  static per-channel bypass; 1 = never gate.
- cg_en  output  N_CH  enable to ICG i (1 = clock runs).
- wake_ack  output  N_CH  one-cycle pulse: channel i clock is running again.
- gated  output  N_CH  status, channel i currently gated.

Behaviour:
- Reset (rst_n=0 at posedge): every channel goes to RUN with idle counter 0.
  - Reset outputs: cg_en all 1, wake_ack all 0, gated all 0.
  - Reset mid-operation from any state aborts it; no wake_ack is produced.
- Channels are fully independent; there is no arbitration between them.
- Per-channel FSM (states RUN, COUNT, GATED, WAKE):
  - RUN: cg_en=1.
    - idle = !busy && !wake_req && !gate_dis.
    - If idle, go to COUNT with counter=1. Otherwise stay.
  - COUNT: cg_en=1.
    - If !idle, go to RUN with counter=0.
    - Else if counter==IDLE_CYC, go to GATED.
    - Else counter+1.
    - Consequence: cg_en falls on the cycle after IDLE_CYC consecutive idle samples.
  - GATED: cg_en=0, gated=1.
    - busy or wake_req or gate_dis moves to WAKE; cg_en=1 from that next cycle.
  - WAKE: cg_en=1, wait counter counts WAKE_LAT cycles.
    - At expiry, go to RUN. wake_ack pulses high for exactly one cycle, in the first RUN cycle, only if wake_req is still high.
    - If wake_req dropped during WAKE, no ack is issued.
- wake_req while in RUN or COUNT:
  - Channel is already clocked; wake_ack pulses the next cycle.
  - Counter resets to 0 and the channel goes to RUN.
  - At most one ack per request: a held wake_req after its ack does not re-ack, but it blocks gating until dropped.
- Registered outputs: cg_en changes only on clk rising edge, giving glitch-free interaction with the latch-based ICG, whose latch is transparent on clk low.
- gate_dis rising in COUNT resets the channel to RUN. In GATED it wakes the channel (no ack).
- Simultaneous busy and wake_req in GATED: single WAKE sequence, single ack.
- IDLE_CYC=1: gating occurs on the 2nd cycle after idle begins.

Optional Feature:
- Macro CLK_GATE_CTRL_STATS_EN.
- Defined: adds per-channel 32-bit saturating counters of gated cycles (cycles with gated=1).
  - Adds output port gated_cnt [N_CH][31:0] and input port stats_clr (1-bit, synchronous, clears all counters).
  - Counters are reset to 0 by rst_n.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package clk_gate_ctrl_pkg holds:
  - typedef enum logic [1:0] cg_state_e {CG_RUN, CG_COUNT, CG_GATED, CG_WAKE}.
  - Localparam STATS_W=32.
- Sub-module clk_gate_chan implements one channel's FSM, idle counter and wake counter (plus the optional stats counter).
- Top-level clk_gate_ctrl instantiates N_CH copies in a generate loop.

Test Plan:
- Reset, then busy=0, wake_req=0, gate_dis=0 on ch0 (IDLE_CYC=16) -> cg_en[0] stays 1 for 16 cycles after idle starts, is 0 from cycle 17, and gated[0]=1.
- Ch0 gated, pulse busy[0]=1 one cycle -> cg_en[0]=1 next cycle; after WAKE_LAT=2 cycles returns to RUN; wake_ack[0] stays 0 throughout.
- Ch1 gated, hold wake_req[1]=1 -> cg_en[1]=1 next cycle; wake_ack[1] single pulse 3 cycles after request; no second pulse while the request is held; no re-gating until the request drops.
- Idle run of 10 cycles, then busy for 1 cycle, then idle again -> counter restarts; gating occurs only after a fresh 16 consecutive idle cycles.
- gate_dis[2]=1 with idle inputs for 100 cycles -> cg_en[2] remains 1. Assert gate_dis[2] while gated -> wakes with no ack.
- rst_n=0 for 1 cycle during WAKE on ch3 -> next cycle cg_en[3]=1, gated[3]=0, no wake_ack.
- With CLK_GATE_CTRL_STATS_EN defined: 40 gated cycles give gated_cnt[0]=40; stats_clr gives 0 the next cycle.
